// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit per clock, LSB first.
// Start/busy/done handshake with a registered final borrow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrw
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             br;

    logic x;
    logic y;
    logic d;
    logic bout;
    logic accept;
    logic last;

    assign accept = (state == S_IDLE) && start;
    assign last   = (cnt == LAST);

    // one full-subtractor slice, reused every SHIFT cycle
    assign x      = sa[0];
    assign y      = sb[0];
    assign d      = x ^ y ^ br;
    assign bout   = (~x & y) | (~(x ^ y) & br);
    assign res_nx = {d, res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            cnt   <= '0;
            br    <= 1'b0;
            diff  <= '0;
            borrw <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            res <= '0;
            cnt <= '0;
            br  <= 1'b0;
        end else if (state == S_SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= res_nx;
            br  <= bout;
            // counter parks at LAST so it never wraps inside an operation
            if (last) begin
                diff  <= res_nx;
                borrw <= bout;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, random sweep
// at WIDTH=8 and an exhaustive sweep at WIDTH=4.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrw;

    logic       start4;
    logic [3:0] a4;
    logic [3:0] b4;
    logic       busy4;
    logic       done4;
    logic [3:0] diff4;
    logic       borrw4;

    int ntot = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .borrw (borrw)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .start (start4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .borrw (borrw4)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        ntot++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // start is raised and held until the DUT reports busy
    task automatic launch8(input logic [7:0] x, input logic [7:0] y);
        bit ok;
        ok    = 1'b0;
        start = 1'b1;
        a     = x;
        b     = y;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(negedge clk);
            if (busy) ok = 1'b1;
        end
        start = 1'b0;
        a     = 8'($urandom);
        b     = 8'($urandom);
        chk("accept8", 32'(busy), 32'd1);
    endtask

    task automatic finish8(input logic [7:0] x, input logic [7:0] y,
                           input string tag, input int poke);
        int n;
        int bc;
        int ed;
        n  = 0;
        bc = 0;
        ed = (int'(x) - int'(y)) & 8'hFF;
        while (!done && n < 40) begin
            if (busy) bc++;
            if (n == poke) begin
                start = 1'b1;
                a     = 8'hAA;
                b     = 8'h55;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " busycyc"}, 32'(bc), 32'd8);
        chk({tag, " busy@done"}, 32'(busy), 32'd0);
        chk({tag, " diff"}, 32'(diff), 32'(ed));
        chk({tag, " borrw"}, 32'(borrw), 32'(int'(x) < int'(y)));
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y,
                       input string tag);
        launch8(x, y);
        finish8(x, y, tag, -1);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y);
        bit ok;
        int n;
        int ed;
        ok     = 1'b0;
        start4 = 1'b1;
        a4     = x;
        b4     = y;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(negedge clk);
            if (busy4) ok = 1'b1;
        end
        start4 = 1'b0;
        a4     = 4'($urandom);
        b4     = 4'($urandom);
        n      = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ed = (int'(x) - int'(y)) & 4'hF;
        chk("w4 latency", 32'(n), 32'd4);
        chk("w4 diff", 32'(diff4), 32'(ed));
        chk("w4 borrw", 32'(borrw4), 32'(int'(x) < int'(y)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst    = 1'b1;
        start  = 1'b0;
        a      = 8'h00;
        b      = 8'h00;
        start4 = 1'b0;
        a4     = 4'h0;
        b4     = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst diff", 32'(diff), 32'd0);
        chk("rst borrw", 32'(borrw), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        op8(8'h05, 8'h03, "05-03");
        @(negedge clk);
        chk("05-03 pulse", 32'(done), 32'd0);
        op8(8'h03, 8'h05, "03-05");
        op8(8'h00, 8'h01, "00-01");
        op8(8'hFF, 8'hFF, "FF-FF");
        op8(8'h80, 8'h7F, "80-7F");
        op8(8'h00, 8'h00, "00-00");

        // starts during SHIFT and DONE must be ignored
        launch8(8'h10, 8'h01);
        finish8(8'h10, 8'h01, "ign", 3);
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h55;
        @(negedge clk);
        chk("ign done1", 32'(done), 32'd0);
        chk("ign idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("held start", 32'(busy), 32'd1);
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        finish8(8'hAA, 8'h55, "held", -1);

        // reset in the 4th busy cycle
        launch8(8'h5A, 8'h21);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst done", 32'(done), 32'd0);
        chk("mrst diff", 32'(diff), 32'd0);
        chk("mrst borrw", 32'(borrw), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mrst nodone", 32'(seen), 32'd0);
        op8(8'h09, 8'h04, "09-04");

        for (int i = 0; i < 200; i++) begin
            logic [7:0] rx;
            logic [7:0] ry;
            rx = 8'($urandom);
            ry = 8'($urandom);
            op8(rx, ry, "rand");
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                op4(4'(x), 4'(y));
            end
        end

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
